// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the hard-decision rate-1/2 Viterbi ACS slice:
// state-count derivation, parity and the expected encoder symbol.
package viterbi_pkg;

  localparam int WB = 2;

  function automatic int m_of(input int k);
    return k - 1;
  endfunction

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  // Window has the branch input bit at w[k-1], then predecessor bits newest
  // (pred[0]) to oldest (pred[k-2]) walking down to w[0].
  function automatic logic [1:0] expected_sym(input int k,
                                               input logic [31:0] g0,
                                               input logic [31:0] g1,
                                               input logic [31:0] pred,
                                               input logic b);
    logic [31:0] w;
    w = '0;
    w[k-1] = b;
    for (int i = 1; i < k; i++) w[k-1-i] = pred[i-1];
    return {parity(g0 & w), parity(g1 & w)};
  endfunction

endpackage

// File: rtl/vit_acs_sel.sv
// Saturating add, compare and select of the two candidate path metrics;
// ties resolve to pred0.
module vit_acs_sel
  import viterbi_pkg::*;
#(
  parameter int Wm = 4
) (
  input  logic [Wm-1:0] pm0,
  input  logic [Wm-1:0] pm1,
  input  logic [WB-1:0] bm0,
  input  logic [WB-1:0] bm1,
  output logic [Wm-1:0] pm_sel,
  output logic          surv
);

  function automatic logic [Wm-1:0] sat_add(input logic [Wm-1:0] pm,
                                            input logic [WB-1:0] bm);
    logic [Wm:0] sum;
    sum = {1'b0, pm} + {{(Wm+1-WB){1'b0}}, bm};
    return sum[Wm] ? {Wm{1'b1}} : sum[Wm-1:0];
  endfunction

  logic [Wm-1:0] m0;
  logic [Wm-1:0] m1;

  assign m0     = sat_add(pm0, bm0);
  assign m1     = sat_add(pm1, bm1);
  assign surv   = (m1 < m0);
  assign pm_sel = surv ? m1 : m0;

endmodule

// File: rtl/vit_expected_sym.sv
// Expected encoder output symbol {c0, c1} for one predecessor/input-bit branch.
module vit_expected_sym
  import viterbi_pkg::*;
#(
  parameter int          K      = 4,
  parameter int unsigned G0_OCT = 'o17,
  parameter int unsigned G1_OCT = 'o13
) (
  input  logic [K-2:0] pred,
  input  logic         b,
  output logic [1:0]   exp_sym
);

  assign exp_sym = expected_sym(K, G0_OCT, G1_OCT, 32'(pred), b);

endmodule

// File: rtl/vit_hamming_bm.sv
// Hard-decision Hamming branch metrics of the received symbol against both
// expected symbols.
module vit_hamming_bm
  import viterbi_pkg::*;
(
  input  logic [1:0]    rx_sym,
  input  logic [1:0]    exp0,
  input  logic [1:0]    exp1,
  output logic [WB-1:0] bm0,
  output logic [WB-1:0] bm1
);

  logic [1:0] d0;
  logic [1:0] d1;

  assign d0  = rx_sym ^ exp0;
  assign d1  = rx_sym ^ exp1;
  assign bm0 = {1'b0, d0[1]} + {1'b0, d0[0]};
  assign bm1 = {1'b0, d1[1]} + {1'b0, d1[0]};

endmodule

// File: rtl/viterbi_bmu_acs.sv
// Per-state add-compare-select slice: combinational predecessor lookup and
// one registered stage of branch metric / survivor results.
module viterbi_bmu_acs
  import viterbi_pkg::*;
#(
  parameter int          K      = 4,
  parameter int          Wm     = 4,
  parameter int unsigned G0_OCT = 'o17,
  parameter int unsigned G1_OCT = 'o13,
  parameter int          Wb     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [K-2:0]  state_idx,
  input  logic [1:0]    rx_sym,
  output logic [K-2:0]  pred0,
  output logic [K-2:0]  pred1,
  input  logic [Wm-1:0] pm0,
  input  logic [Wm-1:0] pm1,
  output logic          out_valid,
  output logic [K-2:0]  out_state,
  output logic [Wm-1:0] pm_out,
  output logic          surv,
  output logic [Wb-1:0] bm0,
  output logic [Wb-1:0] bm1
);

  localparam int M = m_of(K);
  localparam logic [M-1:0] TOP_BIT = M'(1) << (M - 1);

  if (K < 2 || G0_OCT >= (32'd1 << K) || G1_OCT >= (32'd1 << K) || Wb != WB)
  begin : g_bad_param
    $error("viterbi_bmu_acs: illegal K / generator / Wb parameters");
  end

  logic [1:0]    exp0_p0;
  logic [1:0]    exp1_p0;
  logic [WB-1:0] bm0_p0;
  logic [WB-1:0] bm1_p0;
  logic [Wm-1:0] pm_p0;
  logic          surv_p0;

  assign pred0 = state_idx >> 1;
  assign pred1 = pred0 | TOP_BIT;

  vit_expected_sym #(.K(K), .G0_OCT(G0_OCT), .G1_OCT(G1_OCT)) u_exp0 (
    .pred(pred0), .b(state_idx[0]), .exp_sym(exp0_p0)
  );

  vit_expected_sym #(.K(K), .G0_OCT(G0_OCT), .G1_OCT(G1_OCT)) u_exp1 (
    .pred(pred1), .b(state_idx[0]), .exp_sym(exp1_p0)
  );

  vit_hamming_bm u_bm (
    .rx_sym(rx_sym), .exp0(exp0_p0), .exp1(exp1_p0), .bm0(bm0_p0), .bm1(bm1_p0)
  );

  vit_acs_sel #(.Wm(Wm)) u_acs (
    .pm0(pm0), .pm1(pm1), .bm0(bm0_p0), .bm1(bm1_p0), .pm_sel(pm_p0), .surv(surv_p0)
  );

  // p0 -> p1: output register stage
  logic          vld_p1;
  logic [M-1:0]  state_p1;
  logic [Wm-1:0] pm_p1;
  logic          surv_p1;
  logic [WB-1:0] bm0_p1;
  logic [WB-1:0] bm1_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      state_p1 <= '0;
      pm_p1    <= '0;
      surv_p1  <= 1'b0;
      bm0_p1   <= '0;
      bm1_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        state_p1 <= state_idx;
        pm_p1    <= pm_p0;
        surv_p1  <= surv_p0;
        bm0_p1   <= bm0_p0;
        bm1_p1   <= bm1_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_state = state_p1;
  assign pm_out    = pm_p1;
  assign surv      = surv_p1;
  assign bm0       = bm0_p1;
  assign bm1       = bm1_p1;

endmodule

// File: tb/tb_viterbi_bmu_acs.sv
// Scoreboard bench for viterbi_bmu_acs: a driver pushes expectations from an
// encoder-level reference model, a negedge monitor pops and compares.
module tb_viterbi_bmu_acs;

  localparam int K  = 4;
  localparam int M  = 3;
  localparam int S  = 8;
  localparam int WM = 4;
  localparam int PM_MAX = 15;
  localparam int unsigned G0 = 'o17;
  localparam int unsigned G1 = 'o13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [M-1:0]  state_idx = '0;
  logic [1:0]    rx_sym = '0;
  logic [M-1:0]  pred0, pred1;
  logic [WM-1:0] pm0 = '0, pm1 = '0;
  logic          out_valid;
  logic [M-1:0]  out_state;
  logic [WM-1:0] pm_out;
  logic          surv;
  logic [1:0]    bm0, bm1;

  viterbi_bmu_acs #(.K(K), .Wm(WM), .G0_OCT(G0), .G1_OCT(G1), .Wb(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .state_idx(state_idx),
    .rx_sym(rx_sym), .pred0(pred0), .pred1(pred1), .pm0(pm0), .pm1(pm1),
    .out_valid(out_valid), .out_state(out_state), .pm_out(pm_out),
    .surv(surv), .bm0(bm0), .bm1(bm1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int pm;
    int sv;
    int b0;
    int b1;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp = '{0, 0, 0, 0, 0, 0};
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Encoder output for taking input bit b from register contents p:
  // delay line d[0]=b (newest) .. d[K-1]=oldest bit of p.
  function automatic int enc_sym(input int p, input int b);
    int c0, c1, d;
    c0 = 0;
    c1 = 0;
    for (int j = 0; j < K; j++) begin
      d = (j == 0) ? b : ((p >> (j - 1)) & 1);
      if (((G0 >> (K - 1 - j)) & 1) != 0) c0 += d;
      if (((G1 >> (K - 1 - j)) & 1) != 0) c1 += d;
    end
    return (c0 % 2) * 2 + (c1 % 2);
  endfunction

  function automatic int ones2(input int x);
    return (x & 1) + ((x >> 1) & 1);
  endfunction

  function automatic exp_t model(input int s, input int rx, input int p0, input int p1);
    exp_t e;
    int pr0, pr1, m0, m1;
    pr0  = s / 2;
    pr1  = s / 2 + S / 2;
    e.b0 = ones2(rx ^ enc_sym(pr0, s % 2));
    e.b1 = ones2(rx ^ enc_sym(pr1, s % 2));
    m0   = (p0 + e.b0 > PM_MAX) ? PM_MAX : p0 + e.b0;
    m1   = (p1 + e.b1 > PM_MAX) ? PM_MAX : p1 + e.b1;
    e.sv = (m1 < m0) ? 1 : 0;
    e.pm = (m1 < m0) ? m1 : m0;
    e.st = s;
    e.cyc = 0;
    return e;
  endfunction

  task automatic send(input int s, input int rx, input int p0, input int p1);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    state_idx = M'(s);
    rx_sym    = 2'(rx);
    pm0       = WM'(p0);
    pm1       = WM'(p1);
    e = model(s, rx, p0, p1);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    #1;
    check("pred0", int'(pred0), s / 2);
    check("pred1", int'(pred1), s / 2 + S / 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      state_idx = M'($urandom_range(0, S - 1));
      rx_sym    = 2'($urandom_range(0, 3));
      pm0       = WM'($urandom_range(0, PM_MAX));
      pm1       = WM'($urandom_range(0, PM_MAX));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency_cycle", cyc, e.cyc);
          check("out_state", int'(out_state), e.st);
          check("pm_out", int'(pm_out), e.pm);
          check("surv", int'(surv), e.sv);
          check("bm0", int'(bm0), e.b0);
          check("bm1", int'(bm1), e.b1);
          last_exp = e;
        end
      end else begin
        check("hold_out_state", int'(out_state), last_exp.st);
        check("hold_pm_out", int'(pm_out), last_exp.pm);
        check("hold_surv", int'(surv), last_exp.sv);
        check("hold_bm0", int'(bm0), last_exp.b0);
        check("hold_bm1", int'(bm1), last_exp.b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_pm_out", int'(pm_out), 0);
    rst = 1'b0;
    idle(1);

    // Directed cases
    send(0, 0, 0, 5);
    send(1, 3, 3, 0);
    send(0, 0, 2, 0);
    send(0, 3, 14, 15);
    idle(2);

    // Sweep over all target states, back to back
    for (int s = 0; s < S; s++)
      send(s, $urandom_range(0, 3), $urandom_range(0, PM_MAX), $urandom_range(0, PM_MAX));
    idle(3);

    // Asynchronous reset mid-stream: sample in flight is discarded
    send(5, 2, 7, 9);
    send(6, 1, 4, 4);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    state_idx = 3'd7;
    rx_sym    = 2'd3;
    pm0       = 4'd9;
    pm1       = 4'd1;
    #6;
    rst = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_state", int'(out_state), 0);
    check("rst_pm_out", int'(pm_out), 0);
    check("rst_surv", int'(surv), 0);
    check("rst_bm0", int'(bm0), 0);
    check("rst_bm1", int'(bm1), 0);
    exp_q.delete();
    last_exp = '{0, 0, 0, 0, 0, 0};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    idle(2);

    // Randomized traffic with gaps, metrics biased toward saturation
    for (int n = 0; n < 60; n++) begin
      int p0, p1;
      p0 = ($urandom_range(0, 3) == 0) ? $urandom_range(12, PM_MAX) : $urandom_range(0, PM_MAX);
      p1 = ($urandom_range(0, 3) == 0) ? $urandom_range(12, PM_MAX) : $urandom_range(0, PM_MAX);
      send($urandom_range(0, S - 1), $urandom_range(0, 3), p0, p1);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    check("pending_expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_bmu_acs.md
Name: viterbi_bmu_acs

Overview:
- Per-state add-compare-select slice of a hard-decision rate-1/2 Viterbi decoder.
- Given a target trellis state index, it computes the two predecessor states and their expected encoder symbols.
- It then takes Hamming branch metrics against the received symbol, adds them to the supplied predecessor path metrics, and selects the survivor.
- Sits between the symbol-capture/sweep controller and the path-metric bank / survivor memory; results are registered with one-cycle latency.

Parameters:
- K, 4, constraint length (>=2); M=K-1 state bits, S=2^M states.
- Wm, 4, path-metric width.
- G0_OCT, 'o17, generator 0 (K-bit mask; MSB tap = current input bit).
- G1_OCT, 'o13, generator 1.
- Wb, 2, branch-metric width (fixed 2 for hard decision).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  qualifies state_idx/rx_sym/pm0/pm1 this cycle.
- state_idx  in  M  target state s.
- rx_sym  in  2  received symbol; bit1 = G0 output, bit0 = G1 output.
- pred0  out  M  combinational: s>>1.
- pred1  out  M  combinational: (s>>1) | 2^(M-1).
- pm0  in  Wm  path metric of pred0 (read externally via pred0).
- pm1  in  Wm  path metric of pred1.
- out_valid  out  1  registered in_valid.
- out_state  out  M  registered state_idx.
- pm_out  out  Wm  registered survivor metric.
- surv  out  1  registered decision; 0 = pred0, 1 = pred1.
- bm0, bm1  out  Wb  registered branch metrics (debug/verification).

Behaviour:
- Trellis convention: next state = ((pred<<1)|b) mod S; input bit b = s[0] for both branches into s.
- Expected symbol for (pred, b): K-bit window w with:
  - w[K-1] = b;
  - w[K-1-i] = pred[i-1] for i=1..M (pred[0] newest, pred[M-1] oldest → w[0]).
  - c0 = XOR-reduce(G0 & w); c1 = XOR-reduce(G1 & w); exp = {c0, c1}.
- exp0 = expected(pred0, s[0]); exp1 = expected(pred1, s[0]).
- bmX = popcount(rx_sym ^ expX), range 0..2.
- mX = pmX + bmX, saturating at 2^Wm-1; no wrap ever.
- Select:
  - surv = 1 iff m1 < m0 (strict); ties choose pred0 (surv=0).
  - pm_out = min(m0, m1).
- Output timing:
  - On posedge clk with in_valid=1, all registered outputs load the cycle's results and out_valid=1.
  - With in_valid=0, out_valid=0 and the data registers hold their previous values.
- Latency exactly 1 cycle. Throughput 1 state per cycle; back-to-back in_valid is supported with no bubbles. No backpressure.
- pred0/pred1 are purely combinational from state_idx (zero latency) so the PM bank can be read in the same cycle.
- Reset: rst asserted immediately forces out_valid=0, out_state=0, pm_out=0, surv=0, bm0=bm1=0. A sample in flight when rst asserts is discarded. The first valid sample after release produces output one cycle later.
- Metric normalization is the PM bank's responsibility; this block only saturates.
- Elaboration error if K<2 or G0/G1 >= 2^K.

Decomposition:
- Package viterbi_pkg: M/S derivation function, Wb constant, parity function, expected-symbol function (window build + generator masks).
- Sub-modules, all combinational, instanced by viterbi_bmu_acs:
  - vit_expected_sym: one instance per branch.
  - vit_hamming_bm: computes bm0/bm1.
  - vit_acs_sel: saturating add/compare/select.
- Top holds only the pred computation and the output registers.

Test Plan (K=4, M=3, G0=o17, G1=o13, Wm=4):
- Reset: assert rst mid-stream -> out_valid=0, pm_out=0, surv=0, out_state=0, bm0=bm1=0 without waiting for a clock edge.
- s=0, rx=00, pm0=0, pm1=5 -> pred0=0, pred1=4; exp0=00, exp1=11; next cycle bm0=0, bm1=2, pm_out=0, surv=0, out_valid=1.
- s=1, rx=11, pm0=3, pm1=0 -> exp0=11, exp1=00; bm0=0, bm1=2; m0=3, m1=2 -> pm_out=2, surv=1.
- Tie: s=0, rx=00, pm0=2, pm1=0 -> m0=2, m1=2 -> surv=0, pm_out=2.
- Saturation: s=0, rx=11, pm0=14, pm1=15 -> bm0=2, bm1=0, m0 saturates to 15, m1=15 -> pm_out=15, surv=0.
- Sweep: in_valid high for s=0..7 consecutively with random rx/pm -> 8 consecutive out_valid cycles, each matching a golden model computing parity over the window; then in_valid=0 -> out_valid=0 and data outputs hold.
